// File: rtl/dsp_fir_seq.sv
// dsp_fir_seq: time-multiplexed FIR engine with NTAPS programmable taps.
// One sample is accepted per handshake. The engine then runs one MAC per cycle
// over the delay line. It finishes with round, shift and saturate, and holds
// the result on a valid/ready output.
module dsp_fir_seq #(
  parameter int NTAPS     = 8,
  parameter int NBITS_A   = 20,
  parameter int NBITS_B   = 18,
  parameter int NBITS_ACC = 64,
  parameter int NBITS_Z   = 38
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [NBITS_B-1:0]       sample_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NBITS_Z-1:0]       z_o,
  input  logic                     coef_we_i,
  input  logic [$clog2(NTAPS)-1:0] coef_addr_i,
  input  logic [NBITS_A-1:0]       coef_data_i,
  input  logic                     unsigned_a_i,
  input  logic                     unsigned_b_i,
  input  logic [5:0]               shift_right_i,
  input  logic                     round_i,
  input  logic                     saturate_enable_i
);

  localparam int AW   = $clog2(NTAPS);
  localparam int IDXW = AW + 1;
  localparam int PW   = NBITS_A + NBITS_B + 2;
  localparam int VW   = NBITS_ACC + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t               state;
  logic [NBITS_A-1:0]   coef [NTAPS];
  logic [NBITS_B-1:0]   dly  [NTAPS];
  logic [NBITS_ACC-1:0] acc;
  logic [IDXW-1:0]      idx;

  logic       cfg_unsigned_a;
  logic       cfg_unsigned_b;
  logic [5:0] cfg_shift;
  logic       cfg_round;
  logic       cfg_saturate;

  logic signed [NBITS_A:0] a_ext;
  logic signed [NBITS_B:0] b_ext;
  logic signed [PW-1:0]    prod;
  logic [NBITS_ACC-1:0]    prod_ext;

  logic               signed_mode;
  logic [VW-1:0]      pp_ext;
  logic [VW-1:0]      pp_rnd;
  logic [VW-1:0]      pp_shift;
  logic [NBITS_Z-1:0] z_next;

  // Extend the current tap's operands by one bit and form the signed product.
  // idx reaches NTAPS only in the result cycle, when the product is unused.
  always_comb begin
    a_ext    = {~cfg_unsigned_a & coef[idx[AW-1:0]][NBITS_A-1], coef[idx[AW-1:0]]};
    b_ext    = {~cfg_unsigned_b & dly[idx[AW-1:0]][NBITS_B-1], dly[idx[AW-1:0]]};
    prod     = a_ext * b_ext;
    prod_ext = {{(NBITS_ACC-PW){prod[PW-1]}}, prod};
  end

  // Post-process the finished accumulator: round, shift, then saturate or truncate.
  // The work is done one bit wider than the accumulator so that an unsigned
  // value and its rounding bit both fit.
  always_comb begin
    signed_mode = ~(cfg_unsigned_a & cfg_unsigned_b);
    pp_ext      = {signed_mode & acc[NBITS_ACC-1], acc};
    pp_rnd      = pp_ext;
    if (cfg_round && cfg_shift != 6'd0)
      pp_rnd = pp_ext + (VW'(1) << (cfg_shift - 6'd1));
    if (32'(cfg_shift) >= NBITS_ACC)
      pp_shift = {VW{signed_mode & pp_rnd[VW-1]}};
    else if (signed_mode)
      pp_shift = $unsigned($signed(pp_rnd) >>> cfg_shift);
    else
      pp_shift = pp_rnd >> cfg_shift;
    z_next = pp_shift[NBITS_Z-1:0];
    if (cfg_saturate) begin
      if (signed_mode) begin
        if ((|pp_shift[VW-1:NBITS_Z-1]) && !(&pp_shift[VW-1:NBITS_Z-1]))
          z_next = pp_shift[VW-1] ? {1'b1, {(NBITS_Z-1){1'b0}}}
                                  : {1'b0, {(NBITS_Z-1){1'b1}}};
      end else if (|pp_shift[VW-1:NBITS_Z]) begin
        z_next = '1;
      end
    end
  end

  // Control FSM, delay line, coefficient store and accumulator.
  // flush_i overrides everything except reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      in_ready_o     <= 1'b1;
      out_valid_o    <= 1'b0;
      z_o            <= '0;
      acc            <= '0;
      idx            <= '0;
      cfg_unsigned_a <= 1'b0;
      cfg_unsigned_b <= 1'b0;
      cfg_shift      <= '0;
      cfg_round      <= 1'b0;
      cfg_saturate   <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        coef[k] <= '0;
        dly[k]  <= '0;
      end
    end else if (flush_i) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      for (int k = 0; k < NTAPS; k++) dly[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (coef_we_i && (32'(coef_addr_i) < NTAPS))
            coef[coef_addr_i] <= coef_data_i;
          if (in_valid_i) begin
            for (int k = NTAPS - 1; k > 0; k--) dly[k] <= dly[k-1];
            dly[0]         <= sample_i;
            acc            <= '0;
            idx            <= '0;
            cfg_unsigned_a <= unsigned_a_i;
            cfg_unsigned_b <= unsigned_b_i;
            cfg_shift      <= shift_right_i;
            cfg_round      <= round_i;
            cfg_saturate   <= saturate_enable_i;
            in_ready_o     <= 1'b0;
            state          <= MAC;
          end
        end
        MAC: begin
          if (idx == IDXW'(NTAPS)) begin
            z_o         <= z_next;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end else begin
            acc <= acc + prod_ext;
            idx <= idx + IDXW'(1);
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_fir_seq.sv
// Self-checking bench for dsp_fir_seq with a 4-tap, 16-bit-output configuration.
// Expected results are queued at sample accept and compared on output transfer.
module tb_dsp_fir_seq;

  localparam int NTAPS     = 4;
  localparam int NBITS_A   = 20;
  localparam int NBITS_B   = 18;
  localparam int NBITS_ACC = 64;
  localparam int NBITS_Z   = 16;

  logic               clock_i = 1'b0;
  logic               reset_i;
  logic               flush_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [NBITS_B-1:0] sample_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [NBITS_Z-1:0] z_o;
  logic               coef_we_i;
  logic [1:0]         coef_addr_i;
  logic [NBITS_A-1:0] coef_data_i;
  logic               unsigned_a_i;
  logic               unsigned_b_i;
  logic [5:0]         shift_right_i;
  logic               round_i;
  logic               saturate_enable_i;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;
  int last_accept  = 0;
  bit prev_ov      = 1'b0;

  logic [15:0] exp_q [$];
  logic [19:0] m_coef [4];
  logic [17:0] m_dly  [4];

  dsp_fir_seq #(
    .NTAPS(NTAPS), .NBITS_A(NBITS_A), .NBITS_B(NBITS_B),
    .NBITS_ACC(NBITS_ACC), .NBITS_Z(NBITS_Z)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .sample_i(sample_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .z_o(z_o),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .unsigned_a_i(unsigned_a_i), .unsigned_b_i(unsigned_b_i),
    .shift_right_i(shift_right_i), .round_i(round_i),
    .saturate_enable_i(saturate_enable_i)
  );

  // Free-running clock and edge counter used for latency measurement.
  always #5 clock_i = ~clock_i;

  always @(posedge clock_i) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference: exact wide arithmetic, then round, shift and clamp.
  function automatic logic [15:0] model_z();
    logic signed [127:0] sum, a, b, v;
    logic [63:0] acc;
    bit sm;
    int sh;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      a = unsigned_a_i ? $signed({108'd0, m_coef[i]}) : $signed({{108{m_coef[i][19]}}, m_coef[i]});
      b = unsigned_b_i ? $signed({110'd0, m_dly[i]})  : $signed({{110{m_dly[i][17]}}, m_dly[i]});
      sum = sum + a * b;
    end
    acc = sum[63:0];
    sm  = !(unsigned_a_i && unsigned_b_i);
    v   = sm ? $signed({{64{acc[63]}}, acc}) : $signed({64'd0, acc});
    sh  = int'(shift_right_i);
    if (round_i && sh > 0) v = v + (128'sd1 <<< (sh - 1));
    if (sh >= 64) v = (sm && v < 0) ? -128'sd1 : 128'sd0;
    else v = v >>> sh;
    if (saturate_enable_i) begin
      if (sm) begin
        if (v > 128'sd32767) v = 128'sd32767;
        else if (v < -128'sd32768) v = -128'sd32768;
      end else if (v > 128'sd65535) begin
        v = 128'sd65535;
      end
    end
    return v[15:0];
  endfunction

  // Output monitor: latency on each rising valid, scoreboard compare on each transfer.
  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (out_valid_o && !prev_ov)
        checkOutput("latency", 64'(cycle - last_accept), 64'(NTAPS + 1));
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) checkOutput("spurious_valid", 64'(out_valid_o), 64'd0);
        else checkOutput("z_o", 64'(z_o), 64'(exp_q.pop_front()));
      end
    end
    prev_ov = out_valid_o;
  end

  task automatic waitReady();
    int w = 0;
    while (!in_ready_o && w < 200) begin
      @(posedge clock_i); #1;
      w++;
    end
    checkOutput("in_ready_wait", 64'(in_ready_o), 64'd1);
  endtask

  task automatic writeCoef(input logic [1:0] addr, input logic [19:0] data);
    waitReady();
    coef_addr_i = addr;
    coef_data_i = data;
    coef_we_i   = 1'b1;
    @(posedge clock_i); #1;
    coef_we_i    = 1'b0;
    m_coef[addr] = data;
  endtask

  // Drive one sample through the handshake. When push is set, queue either the
  // model result or the supplied constant.
  task automatic applyStimulus(input logic [17:0] s, input bit push, input bit use_model,
                               input logic [15:0] exp_const);
    waitReady();
    sample_i   = s;
    in_valid_i = 1'b1;
    @(posedge clock_i); #1;
    in_valid_i  = 1'b0;
    coef_we_i   = 1'b0;
    last_accept = cycle;
    for (int k = 3; k > 0; k--) m_dly[k] = m_dly[k-1];
    m_dly[0] = s;
    if (push) exp_q.push_back(use_model ? model_z() : exp_const);
  endtask

  task automatic drainOutputs();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid_o) && w < 200) begin
      @(posedge clock_i); #1;
      w++;
    end
    if (w >= 200) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic setConfig(input bit ua, input bit ub, input logic [5:0] sh, input bit rnd, input bit sat);
    unsigned_a_i      = ua;
    unsigned_b_i      = ub;
    shift_right_i     = sh;
    round_i           = rnd;
    saturate_enable_i = sat;
  endtask

  task automatic loadImpulseCoefs();
    for (int i = 0; i < 4; i++) writeCoef(2'(i), 20'(i + 1));
  endtask

  task automatic runImpulse();
    applyStimulus(18'd1, 1, 0, 16'd1);
    applyStimulus(18'd0, 1, 0, 16'd2);
    applyStimulus(18'd0, 1, 0, 16'd3);
    applyStimulus(18'd0, 1, 0, 16'd4);
    applyStimulus(18'd0, 1, 0, 16'd0);
    drainOutputs();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_coef[i] = '0;
      m_dly[i]  = '0;
    end
    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; sample_i = '0;
    out_ready_i = 1'b1; coef_we_i = 1'b0; coef_addr_i = '0; coef_data_i = '0;
    setConfig(0, 0, 6'd0, 0, 0);
    repeat (3) @(posedge clock_i);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset_z", 64'(z_o), 64'd0);
    reset_i = 1'b0;
    @(posedge clock_i); #1;

    $display("[TB] impulse response");
    loadImpulseCoefs();
    runImpulse();

    $display("[TB] rounding");
    writeCoef(2'd0, 20'd6);
    for (int i = 1; i < 4; i++) writeCoef(2'(i), 20'd0);
    setConfig(0, 0, 6'd2, 1, 0);
    applyStimulus(18'd1, 1, 0, 16'd2);
    setConfig(0, 0, 6'd2, 0, 0);
    applyStimulus(18'd1, 1, 0, 16'd1);
    applyStimulus(18'h3FFFF, 1, 0, 16'hFFFE);
    drainOutputs();
    // A coefficient write that coincides with the accept is seen by the MAC.
    coef_addr_i = 2'd0; coef_data_i = 20'd10; coef_we_i = 1'b1;
    m_coef[0] = 20'd10;
    applyStimulus(18'd1, 1, 1, 16'd0);
    drainOutputs();

    $display("[TB] backpressure");
    setConfig(0, 0, 6'd0, 0, 0);
    out_ready_i = 1'b0;
    applyStimulus(18'd3, 1, 0, 16'd30);
    begin
      int w = 0;
      while (!out_valid_o && w < 50) begin
        @(posedge clock_i); #1;
        w++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      checkOutput("hold_valid", 64'(out_valid_o), 64'd1);
      checkOutput("hold_in_ready", 64'(in_ready_o), 64'd0);
      checkOutput("hold_z", 64'(z_o), 64'd30);
      coef_we_i   = (i == 2);
      coef_addr_i = 2'd0;
      coef_data_i = 20'd99;
      @(posedge clock_i); #1;
    end
    coef_we_i   = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clock_i); #1;
    checkOutput("after_xfer_valid", 64'(out_valid_o), 64'd0);
    checkOutput("after_xfer_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("xfer_queue", 64'(exp_q.size()), 64'd0);
    applyStimulus(18'd2, 1, 0, 16'd20);
    drainOutputs();

    $display("[TB] saturation");
    for (int i = 0; i < 4; i++) writeCoef(2'(i), 20'h7FFFF);
    setConfig(0, 0, 6'd0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(18'h1FFFF, 1, 1, 16'd0);
    applyStimulus(18'h1FFFF, 1, 0, 16'h7FFF);
    setConfig(0, 0, 6'd0, 0, 0);
    applyStimulus(18'h1FFFF, 1, 1, 16'd0);
    setConfig(0, 0, 6'd0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(18'h20000, 1, 1, 16'd0);
    applyStimulus(18'h20000, 1, 0, 16'h8000);
    drainOutputs();

    $display("[TB] unsigned mode");
    writeCoef(2'd0, 20'hFFFFF);
    for (int i = 1; i < 4; i++) writeCoef(2'(i), 20'd0);
    setConfig(1, 1, 6'd0, 0, 1);
    applyStimulus(18'h3FFFF, 1, 0, 16'hFFFF);
    setConfig(1, 1, 6'd22, 0, 0);
    applyStimulus(18'h3FFFF, 1, 1, 16'd0);
    setConfig(1, 1, 6'd24, 1, 0);
    applyStimulus(18'h3FFFF, 1, 1, 16'd0);
    drainOutputs();

    $display("[TB] reset mid-MAC");
    setConfig(0, 0, 6'd0, 0, 0);
    loadImpulseCoefs();
    applyStimulus(18'd7, 0, 0, 16'd0);
    @(posedge clock_i); #1;
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    #1;
    checkOutput("async_reset_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("async_reset_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("async_reset_z", 64'(z_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      m_coef[i] = '0;
      m_dly[i]  = '0;
    end
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    repeat (8) @(posedge clock_i);
    #1;
    checkOutput("post_reset_idle", 64'(out_valid_o), 64'd0);

    $display("[TB] flush");
    loadImpulseCoefs();
    applyStimulus(18'd5, 1, 1, 16'd0);
    applyStimulus(18'd7, 1, 1, 16'd0);
    drainOutputs();
    sample_i = 18'd9; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clock_i); #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 4; i++) m_dly[i] = '0;
    checkOutput("flush_no_accept", 64'(in_ready_o), 64'd1);
    applyStimulus(18'd9, 0, 0, 16'd0);
    @(posedge clock_i); #1;
    flush_i = 1'b1;
    @(posedge clock_i); #1;
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) m_dly[i] = '0;
    checkOutput("flush_mac_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("flush_mac_out_valid", 64'(out_valid_o), 64'd0);
    runImpulse();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
